ring_rr_arbiter: RTL and testbench
==================================

# ring_rr_arbiter

One-hot ring-token round-robin arbiter that shares a single resource among N requesters. A registered ring pointer, equivalent to a one-hot ring counter, rotates past each winner so that priority is fair. Grants are bounded by a hold limit and do not preempt. The block sits in the synchronous-counter family and schedules access to a shared datapath such as a counter or accumulator.

## Interface
- N, default 3: number of requesters; N ≥ 2.
- MAX_HOLD, default 4: maximum consecutive grant cycles per win; MAX_HOLD ≥ 1.
- Derived constants:
  - OW = max(1, clog2(N)).
  - CW = clog2(MAX_HOLD+1).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i belongs to requester i; level-sensitive.
- grant  output  N  one-hot registered grant; all-zero when idle.
- busy  output  1  high while any grant is held.
- owner  output  OW  binary index of the current or last grantee.
- ring  output  N  one-hot priority pointer; marks the highest-priority requester.

## Operation
- Internal state:
  - FSM with two states: IDLE and BUSY.
  - Hold counter hcnt, CW bits.
  - ring register.
- Reset, taking priority over all other events, sets:
  - state = IDLE, grant = 0, busy = 0, owner = 0, hcnt = 0, ring = 1 (bit 0 set).
- IDLE:
  - req == 0: stay in IDLE; all outputs hold their values.
  - req != 0: the winner is the first set req bit found by scanning upward from the ring bit, wrapping from bit N-1 to bit 0.
  - On a win: grant = one-hot(winner), owner = winner, busy = 1, hcnt = 1, go to BUSY.
- BUSY, with g = owner:
  - req[g] == 0 or hcnt == MAX_HOLD → release:
    - grant = 0, busy = 0.
    - ring = rotate-left(grant): bit N-1 wraps to bit 0.
    - owner is unchanged; go to IDLE.
  - Otherwise: hcnt = hcnt + 1 and the grant is unchanged.
- No preemption. Requests on other bits during BUSY are ignored until release.
- The ring pointer changes only on release, never in IDLE.
- A requester that drops its request before it is granted loses nothing. Its priority position is unchanged.
- Invariants:
  - grant is zero or exactly one-hot.
  - ring is always exactly one-hot.
  - busy == |grant.

## Timing
- Arbitration latency is 1 cycle. A request sampled on an IDLE edge produces a grant visible immediately after that edge.
- Grant length is min(cycles req[g] stays sampled high after the grant, MAX_HOLD). It is always ≥ 1 cycle.
- Release is registered. grant stays high for the cycle in which req[g] is first seen low, and clears on the next edge.
- Exactly one idle cycle (grant = 0) separates consecutive grants, including when requests are continuous.
- With all requests continuously high, the period is (MAX_HOLD + 1) × N cycles per full rotation.
- MAX_HOLD = 1: every grant lasts exactly 1 cycle.
- Reset asserted mid-grant: grant = 0 and ring = 1 after that edge. Arbitration resumes on the first edge with rst low.
- Simultaneous release and a new request on the same edge: the block takes the release and goes to IDLE. The new request is arbitrated on the following edge.

## Test plan
All scenarios use N=3, MAX_HOLD=4.
- Reset: hold rst=1 for 2 cycles with req=111 → grant=000, busy=0, owner=0, ring=001 throughout; first grant=001 one edge after rst falls.
- Single requester: req=010 held continuously → grant=010 for 4 cycles, then 000 for 1 cycle, then 010 for 4 cycles; ring 001→100 after the first release, 100→100 after the second.
- Full rotation and wrap: req=111 held → grant sequence 001(×4), 000, 010(×4), 000, 100(×4), 000, 001; ring steps 001→010→100→001.
- Early release: req=100 only, dropped one cycle after grant appears → grant=100 for exactly 2 cycles, busy falls with it, ring=001 (wrap), owner stays 2.
- No preemption and skip: grant=001 active, raise req[2] so req=101 → grant stays 001 for the full 4 cycles; after the idle cycle, ring=010 and grant=100 (bit 1 skipped).
- Reset mid-operation: assert rst during the 2nd cycle of grant=010 → after that edge grant=000, ring=001, busy=0, hcnt=0; release rst with req=010 still high → grant=010 one edge later, held for 4 cycles.

Source files
------------

// File: rtl/ring_rr_arbiter.sv
// Ring-token round-robin arbiter: one-hot priority pointer rotates past
// each winner; grants are non-preemptive and capped at MAX_HOLD cycles.
module ring_rr_arbiter #(
  parameter  int N        = 3,
  parameter  int MAX_HOLD = 4,
  localparam int OW       = (N > 2) ? $clog2(N) : 1,
  localparam int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          busy,
  output logic [OW-1:0] owner,
  output logic [N-1:0]  ring
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e        state_q;
  logic [N-1:0]  grant_q;
  logic          busy_q;
  logic [OW-1:0] owner_q;
  logic [CW-1:0] hcnt_q;
  logic [N-1:0]  ring_q;

  logic [OW-1:0] ring_idx;
  logic [OW-1:0] win_d;
  logic          found_d;
  logic          release_d;
  int            idx;

  // Scan upward from the ring bit with wrap; the lowest offset wins.
  always_comb begin
    ring_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ring_q[i]) ring_idx = OW'(i);
    end
    found_d = 1'b0;
    win_d   = '0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ring_idx) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        found_d = 1'b1;
        win_d   = OW'(idx);
      end
    end
  end

  assign release_d = !req[owner_q] ||
                     (hcnt_q == CW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      hcnt_q  <= '0;
      ring_q  <= N'(1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q <= N'(1) << win_d;
            owner_q <= win_d;
            busy_q  <= 1'b1;
            hcnt_q  <= CW'(1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (release_d) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            ring_q  <= {grant_q[N-2:0], grant_q[N-1]};
            state_q <= IDLE;
          end else begin
            hcnt_q  <= hcnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign ring  = ring_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=3, MAX_HOLD=4) against an
// index-based reference model plus hand-computed pins.
module tb_ring_rr_arbiter;

  localparam int N  = 3;
  localparam int MH = 4;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          busy;
  logic [OW-1:0] owner;
  logic [N-1:0]  ring;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .busy  (busy),
    .owner (owner),
    .ring  (ring)
  );

  always #5 clk = ~clk;

  // Reference model: owner index, ring position, hold count.
  int m_owner = 0;
  int m_ring  = 0;
  int m_cnt   = 0;
  bit m_busy  = 0;
  bit chk_en  = 0;

  bit           pin_v = 0;
  logic [N-1:0] pin_g;
  logic [N-1:0] pin_r;
  int           pin_o;

  int vectors = 0;
  int fails   = 0;

  task automatic model_step(input bit r, input logic [N-1:0] q);
    if (r) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ring = 0;
    end else if (!m_busy) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (q[(m_ring + k) % N]) begin
          m_owner = (m_ring + k) % N;
          m_busy  = 1;
          m_cnt   = 1;
        end
      end
    end else if (!q[m_owner] || m_cnt == MH) begin
      m_busy = 0;
      m_ring = (m_owner + 1) % N;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic cyc(input bit r, input logic [N-1:0] q,
                     input bit pv, input logic [N-1:0] pg,
                     input logic [N-1:0] pr, input int po);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    chk_en = 1;
    pin_v  = pv;
    pin_g  = pg;
    pin_r  = pr;
    pin_o  = po;
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] er;
    if (chk_en) begin
      eg = m_busy ? (N'(1) << m_owner) : '0;
      er = N'(1) << m_ring;
      vectors++;
      if (grant !== eg || ring !== er || busy !== m_busy ||
          owner !== OW'(m_owner)) begin
        fails++;
        $display("FAIL model t=%0t grant=%b/%b ring=%b/%b busy=%b/%b owner=%0d/%0d",
                 $time, grant, eg, ring, er, busy, m_busy, owner, m_owner);
      end
      if (pin_v) begin
        vectors++;
        if (grant !== pin_g || ring !== pin_r ||
            owner !== OW'(pin_o) || busy !== (|pin_g)) begin
          fails++;
          $display("FAIL pin t=%0t grant=%b want %b ring=%b want %b owner=%0d want %0d busy=%b",
                   $time, grant, pin_g, ring, pin_r, owner, pin_o, busy);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = '0;
    // reset with all requests up
    cyc(1, 3'b111, 1, 3'b000, 3'b001, 0);
    cyc(1, 3'b111, 1, 3'b000, 3'b001, 0);
    // full rotation and wrap
    cyc(0, 3'b111, 1, 3'b001, 3'b001, 0);
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, 0, 0, 0, 0);
    cyc(0, 3'b111, 1, 3'b000, 3'b010, 0);
    cyc(0, 3'b111, 1, 3'b010, 3'b010, 1);
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, 0, 0, 0, 0);
    cyc(0, 3'b111, 1, 3'b000, 3'b100, 1);
    cyc(0, 3'b111, 1, 3'b100, 3'b100, 2);
    for (int i = 0; i < 3; i++) cyc(0, 3'b111, 0, 0, 0, 0);
    cyc(0, 3'b111, 1, 3'b000, 3'b001, 2);
    cyc(0, 3'b111, 1, 3'b001, 3'b001, 0);
    // single requester
    cyc(1, 3'b000, 1, 3'b000, 3'b001, 0);
    cyc(0, 3'b010, 1, 3'b010, 3'b001, 1);
    for (int i = 0; i < 3; i++) cyc(0, 3'b010, 0, 0, 0, 0);
    cyc(0, 3'b010, 1, 3'b000, 3'b100, 1);
    cyc(0, 3'b010, 1, 3'b010, 3'b100, 1);
    for (int i = 0; i < 3; i++) cyc(0, 3'b010, 0, 0, 0, 0);
    cyc(0, 3'b010, 1, 3'b000, 3'b100, 1);
    // early release
    cyc(1, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b100, 1, 3'b100, 3'b001, 2);
    cyc(0, 3'b100, 1, 3'b100, 3'b001, 2);
    cyc(0, 3'b000, 1, 3'b000, 3'b001, 2);
    cyc(0, 3'b000, 1, 3'b000, 3'b001, 2);
    // no preemption, bit 1 skipped
    cyc(1, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b001, 1, 3'b001, 3'b001, 0);
    for (int i = 0; i < 3; i++) cyc(0, 3'b101, 1, 3'b001, 3'b001, 0);
    cyc(0, 3'b101, 1, 3'b000, 3'b010, 0);
    cyc(0, 3'b101, 1, 3'b100, 3'b010, 2);
    // reset mid-grant
    cyc(1, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b010, 1, 3'b010, 3'b001, 1);
    cyc(0, 3'b010, 1, 3'b010, 3'b001, 1);
    cyc(1, 3'b010, 1, 3'b000, 3'b001, 0);
    cyc(0, 3'b010, 1, 3'b010, 3'b001, 1);
    for (int i = 0; i < 3; i++) cyc(0, 3'b010, 1, 3'b010, 3'b001, 1);
    cyc(0, 3'b010, 1, 3'b000, 3'b100, 1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
